// File: rtl/special_add_if.sv
`default_nettype none
// ============================================================================
// Module      : special_add_if
// Description : Operand/result bundle for the binary32 special-case adder
//               front end.
// Revision    : 1.0 - initial release
// ============================================================================
interface special_add_if;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        symbol;
    logic        out_valid;
    logic [31:0] out;
    logic        check_special;

    // The producer of operands is the master; the adder front end is the slave.
    modport master (
        output in_valid,
        output a,
        output b,
        output symbol,
        input  out_valid,
        input  out,
        input  check_special
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  symbol,
        output out_valid,
        output out,
        output check_special
    );
endinterface
`default_nettype wire

// File: rtl/special_add.sv
`default_nettype none
// ============================================================================
// Module      : special_add
// Description : Special-operand (zero/inf/NaN) resolution for a binary32
//               add/subtract, one registered output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module special_add (
    input  wire logic    clk,
    input  wire logic    rst_n,
    special_add_if.slave bus
);
    localparam logic [31:0] C_QNAN     = 32'h7FC0_0000;
    localparam logic [7:0]  C_EXP_MAX  = 8'hFF;
    localparam logic [22:0] C_MANT_ZERO = 23'd0;

    // Operand B with the subtract sign flip applied.
    logic        w_a_sign;
    logic [7:0]  w_a_exp;
    logic [22:0] w_a_mant;
    logic        w_b_sign;
    logic [7:0]  w_b_exp;
    logic [22:0] w_b_mant;

    assign w_a_sign = bus.a[31];
    assign w_a_exp  = bus.a[30:23];
    assign w_a_mant = bus.a[22:0];
    assign w_b_sign = bus.b[31] ^ bus.symbol;
    assign w_b_exp  = bus.b[30:23];
    assign w_b_mant = bus.b[22:0];

    logic w_a_zero;
    logic w_a_inf;
    logic w_a_nan;
    logic w_b_zero;
    logic w_b_inf;
    logic w_b_nan;

    // Denormals fall through as ordinary operands.
    assign w_a_zero = (w_a_exp == 8'h00)     && (w_a_mant == C_MANT_ZERO);
    assign w_a_inf  = (w_a_exp == C_EXP_MAX) && (w_a_mant == C_MANT_ZERO);
    assign w_a_nan  = (w_a_exp == C_EXP_MAX) && (w_a_mant != C_MANT_ZERO);
    assign w_b_zero = (w_b_exp == 8'h00)     && (w_b_mant == C_MANT_ZERO);
    assign w_b_inf  = (w_b_exp == C_EXP_MAX) && (w_b_mant == C_MANT_ZERO);
    assign w_b_nan  = (w_b_exp == C_EXP_MAX) && (w_b_mant != C_MANT_ZERO);

    logic [31:0] w_result;
    logic        w_special;

    // Priority chain: earlier branches win.
    always_comb begin
        w_result  = 32'h0000_0000;
        w_special = 1'b0;
        if (w_a_nan || w_b_nan) begin
            w_result  = C_QNAN;
            w_special = 1'b1;
        end else if (w_a_inf && w_b_inf) begin
            w_special = 1'b1;
            if (w_a_sign == w_b_sign) begin
                w_result = {w_a_sign, C_EXP_MAX, C_MANT_ZERO};
            end else begin
                w_result = C_QNAN;
            end
        end else if (w_a_inf) begin
            w_result  = bus.a;
            w_special = 1'b1;
        end else if (w_b_inf) begin
            w_result  = {w_b_sign, C_EXP_MAX, C_MANT_ZERO};
            w_special = 1'b1;
        end else if (w_a_zero && w_b_zero) begin
            // -0 only when both effective signs are negative.
            w_result  = {w_a_sign & w_b_sign, 31'd0};
            w_special = 1'b1;
        end else if (w_a_zero) begin
            w_result  = {w_b_sign, bus.b[30:0]};
            w_special = 1'b1;
        end else if (w_b_zero) begin
            w_result  = bus.a;
            w_special = 1'b1;
        end
    end

    logic        r_out_valid;
    logic [31:0] r_out;
    logic        r_check_special;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid     <= 1'b0;
            r_out           <= 32'h0000_0000;
            r_check_special <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_out           <= w_result;
                r_check_special <= w_special;
            end
        end
    end

    assign bus.out_valid     = r_out_valid;
    assign bus.out           = r_out;
    assign bus.check_special = r_check_special;
endmodule
`default_nettype wire

// File: tb/tb_special_add.sv
`default_nettype none
// ============================================================================
// Module      : tb_special_add
// Description : Directed scoreboard bench for special_add.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_special_add;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;

    special_add_if bus ();

    special_add dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sym;
        logic [31:0] o;
        logic        c;
    } vec_t;

    typedef struct {
        logic [31:0] o;
        logic        c;
        int          cyc;
        int          idx;
    } exp_t;

    exp_t sb[$];

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic fail_line(input string name, input logic [31:0] got_o, input logic got_c,
                             input logic [31:0] want_o, input logic want_c);
        failures++;
        $display("FAIL %s: got out=%h chk=%b, want out=%h chk=%b", name, got_o, got_c, want_o, want_c);
    endtask

    // Monitor: pop one expectation per valid output.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    fail_line("unexpected_output", bus.out, bus.check_special, 32'h0, 1'b0);
                end else begin
                    e = sb.pop_front();
                    if (bus.out !== e.o || bus.check_special !== e.c)
                        fail_line($sformatf("vec%0d", e.idx), bus.out, bus.check_special, e.o, e.c);
                    checks++;
                    if (cyc != e.cyc + 1) begin
                        failures++;
                        $display("FAIL latency vec%0d: got %0d cycles, want 1", e.idx, cyc - e.cyc);
                    end
                end
            end
        end
    end

    task automatic issue(input int idx, input logic en);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.a        = vecs[idx].a;
        bus.b        = vecs[idx].b;
        bus.symbol   = vecs[idx].sym;
        if (en) sb.push_back('{o: vecs[idx].o, c: vecs[idx].c, cyc: cyc, idx: idx});
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic check_regs(input string name, input logic [31:0] want_o, input logic want_c,
                              input logic want_v);
        @(negedge clk);
        checks++;
        if (bus.out !== want_o || bus.check_special !== want_c || bus.out_valid !== want_v) begin
            failures++;
            $display("FAIL %s: got out=%h chk=%b vld=%b, want out=%h chk=%b vld=%b", name,
                     bus.out, bus.check_special, bus.out_valid, want_o, want_c, want_v);
        end
    endtask

    initial begin
        int waited;
        checks = 0;
        failures = 0;
        cyc = 0;
        vecs = '{
            '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1},
            '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1},
            '{32'h0000_0000, 32'hC06C_CCCD, 1'b0, 32'hC06C_CCCD, 1'b1},
            '{32'h0000_0000, 32'h406C_CCCD, 1'b1, 32'hC06C_CCCD, 1'b1},
            '{32'h7F80_0000, 32'h0000_0000, 1'b1, 32'h7F80_0000, 1'b1},
            '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1},
            '{32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, 1'b1},
            '{32'hFF80_0000, 32'hFF80_0000, 1'b0, 32'hFF80_0000, 1'b1},
            '{32'hC06C_CCCD, 32'h7F80_0000, 1'b0, 32'h7F80_0000, 1'b1},
            '{32'h406C_CCCD, 32'hFF80_0000, 1'b0, 32'hFF80_0000, 1'b1},
            '{32'hFF80_0001, 32'h406C_CCCD, 1'b0, 32'h7FC0_0000, 1'b1},
            '{32'hFF80_0001, 32'h7F80_0001, 1'b0, 32'h7FC0_0000, 1'b1},
            '{32'h406C_CCCD, 32'h406C_CCCD, 1'b0, 32'h0000_0000, 1'b0},
            '{32'h406C_CCCD, 32'h406C_CCCD, 1'b1, 32'h0000_0000, 1'b0},
            '{32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b1},
            '{32'h0000_0001, 32'h3F80_0000, 1'b0, 32'h0000_0000, 1'b0},
            '{32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 1'b1},
            '{32'h0000_0000, 32'h7FC0_0001, 1'b0, 32'h7FC0_0000, 1'b1},
            '{32'h3F80_0000, 32'h8000_0000, 1'b0, 32'h3F80_0000, 1'b1},
            '{32'h3F80_0000, 32'hFF80_0000, 1'b1, 32'h7F80_0000, 1'b1},
            '{32'h0000_0000, 32'h4000_0000, 1'b1, 32'hC000_0000, 1'b1}
        };

        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.a        = 32'h3F80_0000;
        bus.b        = 32'h8000_0000;
        bus.symbol   = 1'b0;
        repeat (2) @(posedge clk);
        check_regs("reset_state", 32'h0, 1'b0, 1'b0);
        #1;
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;

        // Back-to-back stream of every vector.
        for (int i = 0; i < NV; i++) issue(i, 1'b1);
        idle();
        repeat (2) @(posedge clk);
        check_regs("hold_after_idle", vecs[NV-1].o, vecs[NV-1].c, 1'b0);

        // Reset arrives while the next operation is being presented.
        issue(8, 1'b1);
        @(posedge clk);
        #1;
        bus.a        = vecs[6].a;
        bus.b        = vecs[6].b;
        bus.symbol   = vecs[6].sym;
        rst_n        = 1'b0;
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        check_regs("mid_stream_reset", 32'h0, 1'b0, 1'b0);

        issue(2, 1'b1);
        idle();

        waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d outstanding results, want 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
